// File: rtl/trng_arbiter_if.sv
// Client/core bus for trng_arbiter. Signal names match the original flat port list.
interface trng_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] ack_o;
    logic [31:0]        rand_o;
    logic               trng_request;
    logic [31:0]        trng_random;
    logic               trng_ready;
    logic               busy;
    logic               timeout_err;
    logic               clr_err;

    modport master (
        output req_i, trng_random, trng_ready, clr_err,
        input  ack_o, rand_o, trng_request, busy, timeout_err
    );

    modport slave (
        input  req_i, trng_random, trng_ready, clr_err,
        output ack_o, rand_o, trng_request, busy, timeout_err
    );
endinterface

// File: rtl/trng_arbiter.sv
// Round-robin arbiter sharing one TRNG core among NUM_REQ clients, with a
// per-transaction timeout and a sticky error flag.
module trng_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    trng_arbiter_if.slave  bus
);
    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [PW-1:0]   r_owner, w_owner_nxt;
    logic [TW-1:0]   r_timer, w_timer_nxt;
    logic [31:0]     r_cap, w_cap_nxt;
    logic            r_trng_req, w_trng_req_nxt;
    logic            r_err, w_err_nxt;

    logic [PW-1:0]   w_grant;
    logic            w_grant_vld;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_owner_inc;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        w_idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = PW'((32'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_grant_vld && bus.req_i[w_idx]) begin
                w_grant     = w_idx;
                w_grant_vld = 1'b1;
            end
        end
    end

    assign w_owner_inc = (32'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_timer    <= '0;
            r_cap      <= '0;
            r_trng_req <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_timer    <= w_timer_nxt;
            r_cap      <= w_cap_nxt;
            r_trng_req <= w_trng_req_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_timer_nxt    = r_timer;
        w_cap_nxt      = r_cap;
        w_trng_req_nxt = r_trng_req;
        // A timeout in the same cycle overrides the clear below.
        w_err_nxt      = r_err && !bus.clr_err;

        bus.ack_o        = '0;
        bus.rand_o       = '0;
        bus.trng_request = r_trng_req;
        bus.busy         = (r_state != S_IDLE);
        bus.timeout_err  = r_err;

        unique case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_owner_nxt    = w_grant;
                    w_timer_nxt    = '0;
                    w_trng_req_nxt = 1'b1;
                    w_state_nxt    = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.trng_ready) begin
                    w_cap_nxt      = bus.trng_random;
                    w_trng_req_nxt = 1'b0;
                    w_state_nxt    = S_DONE;
                end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_err_nxt      = 1'b1;
                    w_rr_ptr_nxt   = w_owner_inc;
                    w_trng_req_nxt = 1'b0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_DONE: begin
                bus.ack_o    = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
                bus.rand_o   = r_cap;
                w_cap_nxt    = '0;
                w_rr_ptr_nxt = w_owner_inc;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_trng_arbiter.sv
// Directed bench for trng_arbiter: core responses are driven step by step and
// the expected ack/word pairs are queued, then matched when ack_o pulses.
module tb_trng_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned TO   = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    trng_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    trng_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [3:0]  ack;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every ack must match the head of the scoreboard.
    exp_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ack_o !== '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", {28'b0, bus.ack_o}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("ack_o", {28'b0, bus.ack_o}, {28'b0, e.ack});
                    check("rand_o", bus.rand_o, e.word);
                end
            end else begin
                check("rand_zero", bus.rand_o, 32'h0);
            end
        end
    end

    task automatic serve(input int client, input logic [31:0] word, input int delay);
        int n = 0;
        logic [3:0] oh;
        while (bus.trng_request !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("serve_wait", {31'b0, (n < 40)}, 32'h1);
        repeat (delay) tick();
        oh = 4'b0001 << client;
        bus.trng_ready  = 1'b1;
        bus.trng_random = word;
        sb.push_back('{ack: oh, word: word});
        tick();
        bus.trng_ready  = 1'b0;
        bus.trng_random = $urandom;
        check("req_drop", {31'b0, bus.trng_request}, 32'h0);
        check("busy_done", {31'b0, bus.busy}, 32'h1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},  {28'b0, bus.ack_o}, 32'h0);
        check({tag, "_rand"}, bus.rand_o, 32'h0);
        check({tag, "_treq"}, {31'b0, bus.trng_request}, 32'h0);
        check({tag, "_busy"}, {31'b0, bus.busy}, 32'h0);
        check({tag, "_terr"}, {31'b0, bus.timeout_err}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req_i       = '0;
        bus.trng_ready  = 1'b0;
        bus.trng_random = '0;
        bus.clr_err     = 1'b0;
        rst_n           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // ready while idle is ignored
        bus.trng_ready  = 1'b1;
        bus.trng_random = 32'h1234_5678;
        tick();
        tick();
        check("idle_ready_busy", {31'b0, bus.busy}, 32'h0);
        check("idle_ready_treq", {31'b0, bus.trng_request}, 32'h0);
        bus.trng_ready = 1'b0;
        tick();
        check("idle_busy_after", {31'b0, bus.busy}, 32'h0);

        // all clients requesting: service order 0,1,2,3,0
        bus.req_i = 4'b1111;
        tick();
        check("rr_req_latency", {31'b0, bus.trng_request}, 32'h1);
        for (int w = 1; w <= 5; w++) serve((w - 1) % 4, 32'(w), 1);
        bus.req_i = '0;
        repeat (3) tick();

        // single client, core ready 5 cycles after request
        bus.req_i = 4'b0100;
        tick();
        check("t1_req_latency", {31'b0, bus.trng_request}, 32'h1);
        serve(2, 32'hDEAD_BEEF, 5);
        bus.req_i = '0;
        repeat (3) tick();

        // client 0 drops its request mid-transaction
        bus.req_i = 4'b0011;
        tick();
        check("drop_req_treq", {31'b0, bus.trng_request}, 32'h1);
        bus.req_i = 4'b0010;
        serve(0, 32'hA5A5_0001, 3);
        serve(1, 32'hA5A5_0002, 2);
        bus.req_i = '0;
        repeat (3) tick();

        // timeout with clr_err held: set wins
        bus.clr_err = 1'b1;
        bus.req_i   = 4'b0001;
        tick();
        check("to_treq_start", {31'b0, bus.trng_request}, 32'h1);
        repeat (15) tick();
        check("to_treq_held", {31'b0, bus.trng_request}, 32'h1);
        check("to_err_before", {31'b0, bus.timeout_err}, 32'h0);
        tick();
        check("to_treq_drop", {31'b0, bus.trng_request}, 32'h0);
        check("to_err_set", {31'b0, bus.timeout_err}, 32'h1);
        check("to_busy_idle", {31'b0, bus.busy}, 32'h0);
        bus.clr_err = 1'b0;
        tick();
        check("to_rearb", {31'b0, bus.trng_request}, 32'h1);
        check("to_err_sticky", {31'b0, bus.timeout_err}, 32'h1);
        serve(0, 32'hCAFE_F00D, 2);
        bus.req_i = '0;
        tick();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("to_err_cleared", {31'b0, bus.timeout_err}, 32'h0);
        tick();

        // async reset in the middle of a core transaction
        bus.req_i = 4'b1111;
        tick();
        check("rst_pre_treq", {31'b0, bus.trng_request}, 32'h1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        serve(0, 32'h0000_1000, 1);
        serve(1, 32'h0000_2000, 1);
        bus.req_i = '0;
        repeat (3) tick();

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
